adc_cdac_switch_sequencer: RTL and testbench
============================================

Name: adc_cdac_switch_sequencer

Overview:
- Parametrised, registered successor to the combinational row/column CDAC decoder.
- Accepts binary DAC codes from the SAR logic over a valid/ready handshake and decodes them into active-low row, row-on, column and binary-cap switch controls.
- Holds each code for a programmable settling window, then pulses a settled flag to the comparator strobe logic.
- Optionally inserts a break-before-make all-off cycle between codes.

Parameters:
- ROW_BITS, 4, log2 of unit-array rows (ROWS = 2**ROW_BITS).
- COL_BITS, 5, log2 of unit-array columns (COLS = 2**COL_BITS).
- BIN_BITS, 3, number of binary-weighted LSB caps.
- SETTLE_CYCLES, 2, cycles the outputs are held before settled pulses; legal range 1..255.
- Code width W = ROW_BITS+COL_BITS+BIN_BITS (12 by default).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- code_in  in  W  binary DAC code.
- code_valid  in  1  code_in is valid.
- code_ready  out  1  sequencer can accept a code.
- row_n  out  ROWS  active-low full-row enable.
- rowon_n  out  ROWS  active-low partial-row select.
- col_n  out  COLS  active-low column enable for the partial row.
- bincap_n  out  BIN_BITS  active-low binary-cap enables.
- busy  out  1  a code is applied and settling.
- settled  out  1  single-cycle pulse when the settling window ends.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values:
  - row_n, rowon_n, col_n, bincap_n all ones (every switch off).
  - code_ready=1, busy=0, settled=0.
  - FSM = IDLE, settle counter = 0.
- Decode from latched code C:
  - U = C[W-1:BIN_BITS], r = U>>COL_BITS, c = U[COL_BITS-1:0].
  - row_n[i] = 0 iff i<r.
  - rowon_n[i] = 0 iff i==r.
  - col_n[j] = 0 iff j<c.
  - bincap_n[k] = ~C[k].
  - Unit cell (i,j) is on iff !row_n[i] | (!rowon_n[i] & !col_n[j]).
- All switch outputs are registered; they change only at the acceptance edge (or at BBM exit, below).
- Handshake: transfer occurs when code_valid & code_ready at a rising edge. code_ready = (state==IDLE). code_in is sampled only on transfer.
- FSM:
  - IDLE: on transfer, latch the code, drive the decoded outputs at the same edge (latency 1), load counter = SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: busy=1. If counter==0, then at the next edge go to IDLE and assert settled for exactly that one cycle. Otherwise decrement the counter.
  - Only these two states exist in the base build.
- Outputs hold the last code indefinitely in IDLE, including after settled.
- Back-to-back operation: a new code may be accepted in the same cycle settled is high. Throughput is one code per SETTLE_CYCLES+1 cycles.
- code_valid while busy is ignored; no code is lost because ready=0.
- rst in any state, including mid-SETTLE: the next edge restores the reset values. The rst edge overrides a simultaneous transfer.
- SETTLE_CYCLES outside 1..255 is a build-time error.

Optional Feature:
- Macro: ADC_CDAC_BBM_EN.
- When defined, a BBM state is added. On transfer from IDLE, all switch outputs go to ones for exactly one cycle (busy=1). The decoded code is applied at the following edge and the FSM enters SETTLE. Latency becomes 2 cycles; throughput becomes one code per SETTLE_CYCLES+2 cycles.
- rst during BBM returns to IDLE with reset values.
- When undefined: no BBM state, and timing is as above.

Decomposition:
- Package adc_cdac_pkg holds:
  - Default ROW_BITS, COL_BITS, BIN_BITS, SETTLE_CYCLES.
  - The derived W, ROWS, COLS constants.
  - The FSM state enum (IDLE, BBM, SETTLE).
- Sub-module adc_therm_decoder: purely combinational, parametrised N-bit binary in, 2**N active-low thermometer (i<value) and one-hot (i==value) out. Instantiated once for rows and once for columns; the column instance uses only its thermometer output.

Test Plan:
- Reset, then code 12'd0 with SETTLE_CYCLES=2 -> one edge later: row_n=16'hFFFF, rowon_n=16'hFFFE, col_n=32'hFFFFFFFF, bincap_n=3'b111; busy high for 2 cycles; settled pulses once; code_ready returns to 1.
- Code 12'hFFF -> row_n=16'h8000, rowon_n=16'h7FFF, col_n=32'h80000000, bincap_n=3'b000.
- Code 12'h0A5 (U=20, bin=5) -> row_n=16'hFFFF, rowon_n=16'hFFFE, col_n=32'hFFF00000, bincap_n=3'b010.
- Code_valid held high with codes 12'h100 then 12'h200 -> second code accepted in the settled cycle; 12'h100 outputs remain stable throughout SETTLE; code_valid during busy is ignored.
- rst asserted during the second SETTLE cycle -> next edge: all switch outputs ones, busy=0, settled never pulses, code_ready=1.
- Build with ADC_CDAC_BBM_EN, code 12'hFFF after 12'h000 -> one all-ones cycle, then row_n=16'h8000; settled arrives SETTLE_CYCLES+1 cycles after the all-ones cycle.

Source files
------------

// File: rtl/adc_cdac_pkg.sv
// Shared defaults, derived widths and FSM states for the CDAC switch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package adc_cdac_pkg;

    localparam int DEF_ROW_BITS      = 4;
    localparam int DEF_COL_BITS      = 5;
    localparam int DEF_BIN_BITS      = 3;
    localparam int DEF_SETTLE_CYCLES = 2;

    localparam int W    = DEF_ROW_BITS + DEF_COL_BITS + DEF_BIN_BITS;
    localparam int ROWS = 2 ** DEF_ROW_BITS;
    localparam int COLS = 2 ** DEF_COL_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BBM    = 2'd1,
        SETTLE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/adc_therm_decoder.sv
// Binary value to active-low thermometer (i < value) and active-low one-hot (i == value).
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its input.
module adc_therm_decoder #(
    parameter int N = 4
) (
    input  logic [N-1:0]        value,
    output logic [(2**N)-1:0]   therm_n,
    output logic [(2**N)-1:0]   onehot_n
);

    always_comb begin
        therm_n  = '1;
        onehot_n = '1;
        for (int i = 0; i < 2 ** N; i++) begin
            if (i < int'(value))
                therm_n[i] = 1'b0;
            if (i == int'(value))
                onehot_n[i] = 1'b0;
        end
    end

endmodule

// File: rtl/adc_cdac_switch_sequencer.sv
// Registered CDAC row/column/binary switch sequencer with settling window; optional ADC_CDAC_BBM_EN all-off gap.
// Latency: outputs 1 cycle after acceptance (2 with ADC_CDAC_BBM_EN); settled after SETTLE_CYCLES more.
// Backpressure: code_ready is high only in IDLE; codes offered while busy wait on the producer.
module adc_cdac_switch_sequencer
    import adc_cdac_pkg::*;
#(
    parameter int ROW_BITS      = DEF_ROW_BITS,
    parameter int COL_BITS      = DEF_COL_BITS,
    parameter int BIN_BITS      = DEF_BIN_BITS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ROW_BITS+COL_BITS+BIN_BITS-1:0] code_in,
    input  logic                                code_valid,
    output logic                                code_ready,
    output logic [(2**ROW_BITS)-1:0]            row_n,
    output logic [(2**ROW_BITS)-1:0]            rowon_n,
    output logic [(2**COL_BITS)-1:0]            col_n,
    output logic [BIN_BITS-1:0]                 bincap_n,
    output logic                                busy,
    output logic                                settled
);

    localparam int CW    = ROW_BITS + COL_BITS + BIN_BITS;
    localparam int UW    = ROW_BITS + COL_BITS;
    localparam int NROWS = 2 ** ROW_BITS;
    localparam int NCOLS = 2 ** COL_BITS;

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
            $error("SETTLE_CYCLES must lie in 1..255");
        end
    endgenerate

    seq_state_t  state;
    logic [7:0]  settle_cnt;
    logic [CW-1:0] dec_code;

`ifdef ADC_CDAC_BBM_EN
    logic [CW-1:0] code_q;
    // During the all-off cycle the decoders look at the held code, not the live bus.
    assign dec_code = (state == BBM) ? code_q : code_in;
`else
    assign dec_code = code_in;
`endif

    logic [UW-1:0]        unit_cnt;
    logic [ROW_BITS-1:0]  row_idx;
    logic [COL_BITS-1:0]  col_idx;
    logic [NROWS-1:0]     row_therm_n;
    logic [NROWS-1:0]     row_onehot_n;
    logic [NCOLS-1:0]     col_therm_n;
    logic [NCOLS-1:0]     col_onehot_unused;

    assign unit_cnt = dec_code[CW-1:BIN_BITS];
    assign row_idx  = unit_cnt[UW-1:COL_BITS];
    assign col_idx  = unit_cnt[COL_BITS-1:0];

    adc_therm_decoder #(.N(ROW_BITS)) u_row_dec (
        .value    (row_idx),
        .therm_n  (row_therm_n),
        .onehot_n (row_onehot_n)
    );

    adc_therm_decoder #(.N(COL_BITS)) u_col_dec (
        .value    (col_idx),
        .therm_n  (col_therm_n),
        .onehot_n (col_onehot_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= 8'd0;
            row_n      <= '1;
            rowon_n    <= '1;
            col_n      <= '1;
            bincap_n   <= '1;
            code_ready <= 1'b1;
            busy       <= 1'b0;
            settled    <= 1'b0;
`ifdef ADC_CDAC_BBM_EN
            code_q     <= '0;
`endif
        end else begin
            settled <= 1'b0;
            case (state)
                IDLE: begin
                    if (code_valid) begin
                        code_ready <= 1'b0;
                        busy       <= 1'b1;
`ifdef ADC_CDAC_BBM_EN
                        code_q     <= code_in;
                        row_n      <= '1;
                        rowon_n    <= '1;
                        col_n      <= '1;
                        bincap_n   <= '1;
                        state      <= BBM;
`else
                        row_n      <= row_therm_n;
                        rowon_n    <= row_onehot_n;
                        col_n      <= col_therm_n;
                        bincap_n   <= ~dec_code[BIN_BITS-1:0];
                        settle_cnt <= 8'(SETTLE_CYCLES - 1);
                        state      <= SETTLE;
`endif
                    end
                end
`ifdef ADC_CDAC_BBM_EN
                BBM: begin
                    row_n      <= row_therm_n;
                    rowon_n    <= row_onehot_n;
                    col_n      <= col_therm_n;
                    bincap_n   <= ~dec_code[BIN_BITS-1:0];
                    settle_cnt <= 8'(SETTLE_CYCLES - 1);
                    state      <= SETTLE;
                end
`endif
                SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        state      <= IDLE;
                        settled    <= 1'b1;
                        busy       <= 1'b0;
                        code_ready <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    code_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_cdac_switch_sequencer.sv
// Randomized plus directed bench for the CDAC switch sequencer against a cycle-count reference model.
module tb_adc_cdac_switch_sequencer;
    import adc_cdac_pkg::*;

    localparam int S = DEF_SETTLE_CYCLES;
`ifdef ADC_CDAC_BBM_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif
    localparam int IDLE_K = 1000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [W-1:0]    code_in = '0;
    logic            code_valid = 1'b0;
    logic            code_ready;
    logic [ROWS-1:0] row_n;
    logic [ROWS-1:0] rowon_n;
    logic [COLS-1:0] col_n;
    logic [DEF_BIN_BITS-1:0] bincap_n;
    logic            busy;
    logic            settled;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    adc_cdac_switch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .row_n      (row_n),
        .rowon_n    (rowon_n),
        .col_n      (col_n),
        .bincap_n   (bincap_n),
        .busy       (busy),
        .settled    (settled)
    );

    always #5 clk = ~clk;

    // Model: cycles elapsed since the last accepted code (IDLE_K means none pending).
    int           m_k = IDLE_K;
    logic         m_have = 1'b0;
    logic [W-1:0] m_code = '0;

    function automatic logic m_ready();
        return m_k > S + B;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_k    <= IDLE_K;
            m_have <= 1'b0;
        end else if (code_valid && m_ready()) begin
            m_code <= code_in;
            m_have <= 1'b1;
            m_k    <= 1;
        end else if (m_k < IDLE_K) begin
            m_k <= m_k + 1;
        end
    end

    function automatic int unit_of(input logic [W-1:0] c);
        return int'(c) >> DEF_BIN_BITS;
    endfunction

    function automatic logic [31:0] exp_row(input logic [W-1:0] c);
        longint one = 1;
        return 32'(~((one << (unit_of(c) / COLS)) - 1));
    endfunction

    function automatic logic [31:0] exp_rowon(input logic [W-1:0] c);
        longint one = 1;
        return 32'(~(one << (unit_of(c) / COLS)));
    endfunction

    function automatic logic [31:0] exp_col(input logic [W-1:0] c);
        longint one = 1;
        return 32'(~((one << (unit_of(c) % COLS)) - 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic all_off;
            all_off = !m_have || (B == 1 && m_k == 1);
            chk("row_n",    32'(row_n),    all_off ? 32'(16'hFFFF) : 32'(exp_row(m_code) & 32'hFFFF));
            chk("rowon_n",  32'(rowon_n),  all_off ? 32'(16'hFFFF) : 32'(exp_rowon(m_code) & 32'hFFFF));
            chk("col_n",    32'(col_n),    all_off ? 32'hFFFFFFFF : exp_col(m_code));
            chk("bincap_n", 32'(bincap_n), all_off ? 32'd7 : 32'(~m_code[2:0] & 3'b111));
            chk("busy",     32'(busy),     32'(m_k >= 1 && m_k <= S + B));
            chk("settled",  32'(settled),  32'(m_k == S + B + 1));
            chk("ready",    32'(code_ready), 32'(m_ready()));
        end
    end

    // Offers one code while the DUT is idle; returns just after the acceptance edge.
    task automatic send(input logic [W-1:0] c);
        code_in    = c;
        code_valid = 1'b1;
        @(posedge clk);
        #1 code_valid = 1'b0;
    endtask

    task automatic gap();
        repeat (S + B + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_row_n", 32'(row_n), 32'h0000FFFF);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ready", 32'(code_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        gap();

        send(12'h000);
        repeat (B) @(posedge clk);
        @(negedge clk);
        chk("c000_rowon", 32'(rowon_n), 32'h0000FFFE);
        chk("c000_col",   32'(col_n), 32'hFFFFFFFF);
        gap();

        send(12'hFFF);
        repeat (B) @(posedge clk);
        @(negedge clk);
        chk("cfff_row",   32'(row_n), 32'h00008000);
        chk("cfff_rowon", 32'(rowon_n), 32'h00007FFF);
        chk("cfff_col",   32'(col_n), 32'h80000000);
        chk("cfff_bin",   32'(bincap_n), 32'd0);
        gap();

        send(12'h0A5);
        repeat (B) @(posedge clk);
        @(negedge clk);
        chk("c0a5_row", 32'(row_n), 32'h0000FFFF);
        chk("c0a5_col", 32'(col_n), 32'hFFF00000);
        chk("c0a5_bin", 32'(bincap_n), 32'd2);
        gap();

        code_in    = 12'h100;
        code_valid = 1'b1;
        @(posedge clk);
        #1 code_in = 12'h200;
        repeat (S + B) @(posedge clk);
        @(negedge clk);
        chk("b2b_settled", 32'(settled), 32'd1);
        chk("b2b_hold_row", 32'(row_n), 32'h0000FFFE);
        @(posedge clk);
        #1 code_valid = 1'b0;
        repeat (B) @(posedge clk);
        @(negedge clk);
        chk("b2b_second_row", 32'(row_n), 32'h0000FFFC);
        gap();

        send(12'hFFF);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_row",  32'(row_n), 32'h0000FFFF);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(code_ready), 32'd1);
        gap();

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst        = ($urandom_range(0, 299) == 0);
            code_valid = $urandom_range(0, 1) == 1;
            code_in    = W'($urandom);
        end
        @(posedge clk);
        #1 code_valid = 1'b0;
        rst = 1'b0;
        gap();
        @(negedge clk);
        chk_en = 1'b0;
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
